// File: rtl/board_pkg.sv
// Board-wide constants, time helpers and the debouncer state encoding shared
// by the pin-input blocks on the 12 MHz learning board.
package board_pkg;

  localparam int unsigned CLK_HZ_DEFAULT = 12000000;

  // Integer cycle count for a duration in milliseconds at the given clock.
  function automatic int unsigned ms_to_cycles(input int unsigned clk_hz,
                                               input int unsigned ms);
    return (clk_hz / 1000) * ms;
  endfunction

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    ARM_PRESS   = 2'd1,
    PRESSED     = 2'd2,
    ARM_RELEASE = 2'd3
  } deb_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous pin; the reset value is
// chosen by the user so the idle pin level is seen straight out of reset.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic s1_q;
  logic s2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= RESET_VAL;
      s2_q <= RESET_VAL;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;

endmodule

// File: rtl/button_debouncer.sv
// Push-button conditioner: synchronises the raw pin, rejects contact bounce and
// emits a clean level plus one-cycle press, release and long-press pulses.
module button_debouncer
  import board_pkg::*;
#(
  parameter int unsigned CLK_HZ          = CLK_HZ_DEFAULT,
  parameter int unsigned DEBOUNCE_CYCLES = ms_to_cycles(CLK_HZ, 10),   // >= 2
  parameter int unsigned LONG_CYCLES     = ms_to_cycles(CLK_HZ, 1000), // > DEBOUNCE_CYCLES
  parameter bit          ACTIVE_LOW      = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_raw,
  output logic       btn_level,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic       long_press,
  output deb_state_e dbg_state_o
);

  localparam int unsigned DEB_W  = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned HOLD_W = $clog2(LONG_CYCLES);
  localparam logic [DEB_W-1:0]  DEB_MAX  = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_CYCLES - 1);

  logic sync_q;
  logic pressed_s;

  sync_2ff #(
    .RESET_VAL (ACTIVE_LOW)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (btn_raw),
    .q_o   (sync_q)
  );

  assign pressed_s = sync_q ^ ACTIVE_LOW;

  deb_state_e        state_q, state_d;
  logic [DEB_W-1:0]  deb_cnt_q, deb_cnt_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic              long_done_q, long_done_d;
  logic              level_q, level_d;
  logic              press_q, press_d;
  logic              release_q, release_d;
  logic              long_q, long_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      deb_cnt_q   <= '0;
      hold_cnt_q  <= '0;
      long_done_q <= 1'b0;
      level_q     <= 1'b0;
      press_q     <= 1'b0;
      release_q   <= 1'b0;
      long_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      deb_cnt_q   <= deb_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
      long_done_q <= long_done_d;
      level_q     <= level_d;
      press_q     <= press_d;
      release_q   <= release_d;
      long_q      <= long_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    deb_cnt_d   = deb_cnt_q;
    hold_cnt_d  = hold_cnt_q;
    long_done_d = long_done_q;
    level_d     = level_q;
    press_d     = 1'b0;
    release_d   = 1'b0;
    long_d      = 1'b0;

    // Hold time keeps running while a release is being debounced, so a long
    // press can still fire during ARM_RELEASE.
    if (state_q == PRESSED || state_q == ARM_RELEASE) begin
      if (hold_cnt_q != HOLD_MAX) begin
        hold_cnt_d = hold_cnt_q + 1'b1;
      end else if (!long_done_q) begin
        long_d      = 1'b1;
        long_done_d = 1'b1;
      end
    end

    case (state_q)
      IDLE: begin
        if (pressed_s) begin
          state_d   = ARM_PRESS;
          deb_cnt_d = '0;
        end
      end
      ARM_PRESS: begin
        if (!pressed_s) begin
          state_d = IDLE;
        end else if (deb_cnt_q == DEB_MAX) begin
          state_d     = PRESSED;
          press_d     = 1'b1;
          level_d     = 1'b1;
          hold_cnt_d  = '0;
          long_done_d = 1'b0;
        end else begin
          deb_cnt_d = deb_cnt_q + 1'b1;
        end
      end
      PRESSED: begin
        if (!pressed_s) begin
          state_d   = ARM_RELEASE;
          deb_cnt_d = '0;
        end
      end
      ARM_RELEASE: begin
        if (pressed_s) begin
          state_d = PRESSED;
        end else if (deb_cnt_q == DEB_MAX) begin
          state_d     = IDLE;
          release_d   = 1'b1;
          level_d     = 1'b0;
          long_done_d = 1'b0;
        end else begin
          deb_cnt_d = deb_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign btn_level     = level_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign long_press    = long_q;
  assign dbg_state_o   = state_q;

endmodule
